ram_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the 32 x 16-bit single-port RAM (`RAM`: `clk`, `data_in`, `address`, `wrenable`, `rdenable`, `data_out`).
- Accepts one read or write command from each of two requesters (A, B) through a req/gnt handshake.
- Serialises the commands onto the RAM's single port and returns read data with a one-cycle `rvalid` pulse.
- Sits between the RAM and its clients (e.g. ALU result store and debug/load port).

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/ram_arbiter_rr_pick2.sv | 24 ++
 rtl/ram_arbiter.sv | 126 ++++++++++++
 tb/tb_ram_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM arbiter.
// State encoding, default widths, port-select codes.
package ram_arb_pkg;

  localparam int DEF_AW = 5;
  localparam int DEF_DW = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick.
// Ports: req_a, req_b, last in; sel (winner), any out.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic sel,
  output logic any
);

  always_comb begin
    sel = PORT_A;
    unique case (1'b1)
      (req_a && req_b): sel = ~last;
      (req_b && !req_a): sel = PORT_B;
      default: sel = PORT_A;
    endcase
  end

  assign any = req_a | req_b;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer for a single-port RAM.
// Ports: clk, rst, A/B req/we/addr/wdata in, gnt/rvalid/rdata out, busy, ram_* side.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          we_a,
  input  logic          we_b,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_a,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic          busy,
  output logic [DW-1:0] ram_data_in,
  output logic [AW-1:0] ram_address,
  output logic          ram_wrenable,
  output logic          ram_rdenable,
  input  logic [DW-1:0] ram_data_out
);

  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_sel;
  logic          r_last;
  logic          r_we;
  logic [1:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata_a;
  logic [DW-1:0] r_rdata_b;
  logic          r_rvalid_a;
  logic          r_rvalid_b;
  logic          w_sel;
  logic          w_any;
  logic          w_issue;

  rr_pick2 u_pick (
    .req_a (req_a),
    .req_b (req_b),
    .last  (r_last),
    .sel   (w_sel),
    .any   (w_any)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = S_ISSUE;
      S_ISSUE: w_next = r_we ? S_IDLE : S_WAIT;
      S_WAIT:  if (r_cnt == 2'd0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sel      <= PORT_A;
      r_last     <= PORT_B;
      r_we       <= 1'b0;
      r_cnt      <= 2'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
      if (r_state == S_IDLE && w_any) begin
        r_sel   <= w_sel;
        r_last  <= w_sel;
        r_we    <= (w_sel == PORT_B) ? we_b : we_a;
        r_addr  <= (w_sel == PORT_B) ? addr_b : addr_a;
        r_wdata <= (w_sel == PORT_B) ? wdata_b : wdata_a;
      end
      if (r_state == S_ISSUE) r_cnt <= LAT_M1;
      if (r_state == S_WAIT) begin
        if (r_cnt == 2'd0) begin
          if (r_sel == PORT_B) begin
            r_rdata_b  <= ram_data_out;
            r_rvalid_b <= 1'b1;
          end else begin
            r_rdata_a  <= ram_data_out;
            r_rvalid_a <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt - 2'd1;
        end
      end
    end
  end

  // Enables and grants are decoded from state so they can only
  // be high during the single ISSUE cycle.
  assign w_issue      = (r_state == S_ISSUE);
  assign gnt_a        = w_issue && (r_sel == PORT_A);
  assign gnt_b        = w_issue && (r_sel == PORT_B);
  assign ram_wrenable = w_issue && r_we;
  assign ram_rdenable = w_issue && !r_we;
  assign busy         = (r_state != S_IDLE);
  assign ram_address  = r_addr;
  assign ram_data_in  = r_wdata;
  assign rvalid_a     = r_rvalid_a;
  assign rvalid_b     = r_rvalid_b;
  assign rdata_a      = r_rdata_a;
  assign rdata_b      = r_rdata_b;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with behavioural RAM models.
// Covers RD_LAT=1 and an RD_LAT=3 instance.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_a = 0, req_b = 0, we_a = 0, we_b = 0;
  logic [4:0]  addr_a = 0, addr_b = 0;
  logic [15:0] wdata_a = 0, wdata_b = 0;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b, busy;
  logic [15:0] rdata_a, rdata_b, ram_data_in, ram_data_out;
  logic [4:0]  ram_address;
  logic        ram_wrenable, ram_rdenable;

  logic        z_req_a = 0, z_we_a = 0;
  logic [4:0]  z_addr_a = 0;
  logic [15:0] z_wdata_a = 0;
  logic        z_gnt_a, z_gnt_b, z_rvalid_a, z_rvalid_b, z_busy;
  logic [15:0] z_rdata_a, z_rdata_b, z_ram_data_in, z_ram_data_out;
  logic [4:0]  z_ram_address;
  logic        z_ram_wrenable, z_ram_rdenable;

  int n_chk = 0;
  int n_pass = 0;
  int both_hi = 0;
  int en_bad = 0;

  ram_arbiter #(.AW(5), .DW(16), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy),
    .ram_data_in(ram_data_in), .ram_address(ram_address),
    .ram_wrenable(ram_wrenable), .ram_rdenable(ram_rdenable),
    .ram_data_out(ram_data_out)
  );

  ram_arbiter #(.AW(5), .DW(16), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_a(z_req_a), .req_b(1'b0), .we_a(z_we_a), .we_b(1'b0),
    .addr_a(z_addr_a), .addr_b(5'd0),
    .wdata_a(z_wdata_a), .wdata_b(16'd0),
    .gnt_a(z_gnt_a), .gnt_b(z_gnt_b),
    .rvalid_a(z_rvalid_a), .rvalid_b(z_rvalid_b),
    .rdata_a(z_rdata_a), .rdata_b(z_rdata_b), .busy(z_busy),
    .ram_data_in(z_ram_data_in), .ram_address(z_ram_address),
    .ram_wrenable(z_ram_wrenable), .ram_rdenable(z_ram_rdenable),
    .ram_data_out(z_ram_data_out)
  );

  // RAM models: read data registered on the enable edge,
  // the RD_LAT=3 model adds two more pipeline stages.
  logic [15:0] mem [32];
  logic [15:0] zmem [32];
  logic [15:0] rd1 = 0, zp1 = 0, zp2 = 0, zp3 = 0;
  initial for (int i = 0; i < 32; i++) begin
    mem[i] = 16'h0;
    zmem[i] = 16'h0;
  end
  always @(posedge clk) begin
    if (ram_wrenable) mem[ram_address] <= ram_data_in;
    if (ram_rdenable) rd1 <= mem[ram_address];
    if (z_ram_wrenable) zmem[z_ram_address] <= z_ram_data_in;
    if (z_ram_rdenable) zp1 <= zmem[z_ram_address];
    zp2 <= zp1;
    zp3 <= zp2;
  end
  assign ram_data_out = rd1;
  assign z_ram_data_out = zp3;

  always @(negedge clk) begin
    if (ram_wrenable && ram_rdenable) both_hi++;
    if (z_ram_wrenable && z_ram_rdenable) both_hi++;
    if ((ram_wrenable | ram_rdenable) != (gnt_a | gnt_b)) en_bad++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic r, input logic w,
                       input logic [4:0] a, input logic [15:0] d);
    req_a = r; we_a = w; addr_a = a; wdata_a = d;
  endtask

  task automatic set_b(input logic r, input logic w,
                       input logic [4:0] a, input logic [15:0] d);
    req_b = r; we_b = w; addr_b = a; wdata_b = d;
  endtask

  task automatic wr(input bit p, input logic [4:0] a,
                    input logic [15:0] d, output bit ok);
    ok = 0;
    if (!p) set_a(1, 1, a, d);
    else set_b(1, 1, a, d);
    for (int i = 0; i < 8 && !ok; i++) begin
      tick;
      if ((!p && gnt_a) || (p && gnt_b)) ok = 1;
    end
    if (!p) set_a(0, 0, 0, 0);
    else set_b(0, 0, 0, 0);
    tick;
  endtask

  task automatic rd(input bit p, input logic [4:0] a,
                    output logic [15:0] d, output int lat);
    bit got;
    got = 0;
    lat = -1;
    d = 16'h0;
    if (!p) set_a(1, 0, a, 0);
    else set_b(1, 0, a, 0);
    for (int i = 1; i <= 12 && !got; i++) begin
      tick;
      if (!p && gnt_a) set_a(0, 0, 0, 0);
      if (p && gnt_b) set_b(0, 0, 0, 0);
      if (!p && rvalid_a) begin got = 1; d = rdata_a; lat = i; end
      if (p && rvalid_b) begin got = 1; d = rdata_b; lat = i; end
    end
    if (!p) set_a(0, 0, 0, 0);
    else set_b(0, 0, 0, 0);
  endtask

  task automatic test_reset;
    rst = 1;
    tick;
    tick;
    n_chk++;
    if ({gnt_a, gnt_b, rvalid_a, rvalid_b, busy,
         ram_wrenable, ram_rdenable} !== 7'b0)
      $display("FAIL reset_ctl got=%b exp=0",
               {gnt_a, gnt_b, rvalid_a, rvalid_b, busy,
                ram_wrenable, ram_rdenable});
    else n_pass++;
    n_chk++;
    if ({rdata_a, rdata_b, ram_address, ram_data_in} !== 53'b0)
      $display("FAIL reset_data got=%h %h %h %h exp=0",
               rdata_a, rdata_b, ram_address, ram_data_in);
    else n_pass++;
    rst = 0;
    tick;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL idle_busy got=%b exp=0", busy);
    else n_pass++;
  endtask

  task automatic test_write_read;
    set_a(1, 1, 5'd0, 16'h1234);
    tick;
    n_chk++;
    if ({gnt_a, gnt_b, ram_wrenable, ram_rdenable, ram_address,
         ram_data_in} !== {4'b1010, 5'd0, 16'h1234})
      $display("FAIL t1_wr_issue got=%b%b%b%b %h %h exp=1010 00 1234",
               gnt_a, gnt_b, ram_wrenable, ram_rdenable,
               ram_address, ram_data_in);
    else n_pass++;
    set_a(0, 0, 0, 0);
    tick;
    n_chk++;
    if ({gnt_a, busy} !== 2'b00)
      $display("FAIL t1_wr_done got=%b exp=00", {gnt_a, busy});
    else n_pass++;
    set_a(1, 0, 5'd0, 0);
    tick;
    n_chk++;
    if ({gnt_a, ram_rdenable, ram_wrenable} !== 3'b110)
      $display("FAIL t1_rd_issue got=%b exp=110",
               {gnt_a, ram_rdenable, ram_wrenable});
    else n_pass++;
    set_a(0, 0, 0, 0);
    tick;
    n_chk++;
    if ({rvalid_a, busy, ram_rdenable} !== 3'b010)
      $display("FAIL t1_wait got=%b exp=010",
               {rvalid_a, busy, ram_rdenable});
    else n_pass++;
    tick;
    n_chk++;
    if ({rvalid_a, rdata_a} !== {1'b1, 16'h1234})
      $display("FAIL t1_rvalid got=%b %h exp=1 1234", rvalid_a, rdata_a);
    else n_pass++;
    tick;
    n_chk++;
    if ({rvalid_a, rdata_a} !== {1'b0, 16'h1234})
      $display("FAIL t1_hold got=%b %h exp=0 1234", rvalid_a, rdata_a);
    else n_pass++;
  endtask

  task automatic test_tie;
    logic [15:0] d;
    int l;
    rst = 1;
    tick;
    rst = 0;
    set_a(1, 1, 5'd2, 16'h9ABC);
    set_b(1, 1, 5'd3, 16'hDEF0);
    tick;
    n_chk++;
    if ({gnt_a, gnt_b} !== 2'b10)
      $display("FAIL t2_first got=%b exp=10", {gnt_a, gnt_b});
    else n_pass++;
    set_a(0, 0, 0, 0);
    tick;
    n_chk++;
    if (gnt_b !== 1'b0) $display("FAIL t2_gap got=%b exp=0", gnt_b);
    else n_pass++;
    tick;
    n_chk++;
    if ({gnt_b, ram_wrenable, ram_address, ram_data_in} !==
        {2'b11, 5'd3, 16'hDEF0})
      $display("FAIL t2_second got=%b%b %h %h exp=11 03 def0",
               gnt_b, ram_wrenable, ram_address, ram_data_in);
    else n_pass++;
    set_b(0, 0, 0, 0);
    tick;
    rd(0, 5'd2, d, l);
    n_chk++;
    if (d !== 16'h9ABC) $display("FAIL t2_rd_a got=%h exp=9abc", d);
    else n_pass++;
    rd(1, 5'd3, d, l);
    n_chk++;
    if ({d, l} !== {16'hDEF0, 32'd3})
      $display("FAIL t2_rd_b got=%h lat=%0d exp=def0 lat=3", d, l);
    else n_pass++;
  endtask

  task automatic test_alternate;
    bit [5:0] ord;
    int n;
    ord = 0;
    n = 0;
    set_a(1, 1, 5'd10, 16'hAAAA);
    set_b(1, 1, 5'd11, 16'hBBBB);
    for (int i = 0; i < 20 && n < 6; i++) begin
      tick;
      if (gnt_a || gnt_b) begin
        ord[n] = gnt_b;
        n++;
      end
    end
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    tick;
    n_chk++;
    if (n !== 6) $display("FAIL t3_count got=%0d exp=6", n);
    else n_pass++;
    n_chk++;
    if (ord !== 6'b101010)
      $display("FAIL t3_order got=%b exp=101010", ord);
    else n_pass++;
  endtask

  task automatic test_rw_hazard;
    bit ok;
    logic [15:0] d;
    int l;
    wr(0, 5'd4, 16'h1111, ok);
    n_chk++;
    if (ok !== 1'b1) $display("FAIL t4_pre got=%b exp=1", ok);
    else n_pass++;
    set_a(1, 1, 5'd4, 16'hFEDC);
    set_b(1, 0, 5'd4, 0);
    tick;
    n_chk++;
    if ({gnt_a, gnt_b, ram_rdenable} !== 3'b011)
      $display("FAIL t4_b_wins got=%b exp=011",
               {gnt_a, gnt_b, ram_rdenable});
    else n_pass++;
    set_b(0, 0, 0, 0);
    tick;
    tick;
    n_chk++;
    if ({rvalid_b, rdata_b} !== {1'b1, 16'h1111})
      $display("FAIL t4_old got=%b %h exp=1 1111", rvalid_b, rdata_b);
    else n_pass++;
    tick;
    n_chk++;
    if ({gnt_a, ram_wrenable, ram_address, ram_data_in} !==
        {2'b11, 5'd4, 16'hFEDC})
      $display("FAIL t4_a_wr got=%b%b %h %h exp=11 04 fedc",
               gnt_a, ram_wrenable, ram_address, ram_data_in);
    else n_pass++;
    set_a(0, 0, 0, 0);
    tick;
    rd(1, 5'd4, d, l);
    n_chk++;
    if (d !== 16'hFEDC) $display("FAIL t4_new got=%h exp=fedc", d);
    else n_pass++;
  endtask

  task automatic test_reset_wait;
    bit got;
    set_a(1, 0, 5'd0, 0);
    tick;
    set_a(0, 0, 0, 0);
    tick;
    n_chk++;
    if ({busy, rvalid_a} !== 2'b10)
      $display("FAIL t5_in_wait got=%b exp=10", {busy, rvalid_a});
    else n_pass++;
    rst = 1;
    tick;
    rst = 0;
    n_chk++;
    if ({gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ram_wrenable,
         ram_rdenable, rdata_a, rdata_b, ram_address,
         ram_data_in} !== 60'b0)
      $display("FAIL t5_cleared got=%b%b%b%b%b%b%b %h %h %h %h exp=0",
               gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ram_wrenable,
               ram_rdenable, rdata_a, rdata_b, ram_address, ram_data_in);
    else n_pass++;
    tick;
    n_chk++;
    if (rvalid_a !== 1'b0) $display("FAIL t5_no_rvalid got=%b exp=0", rvalid_a);
    else n_pass++;
    set_a(1, 1, 5'd20, 16'h0001);
    set_b(1, 1, 5'd21, 16'h0002);
    tick;
    n_chk++;
    if ({gnt_a, gnt_b} !== 2'b10)
      $display("FAIL t5_a_prio got=%b exp=10", {gnt_a, gnt_b});
    else n_pass++;
    set_a(0, 0, 0, 0);
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      tick;
      if (gnt_b) got = 1;
    end
    set_b(0, 0, 0, 0);
    tick;
    n_chk++;
    if (got !== 1'b1) $display("FAIL t5_b_next got=%b exp=1", got);
    else n_pass++;
  endtask

  task automatic test_lat3;
    bit ok;
    bit got;
    int l;
    logic [15:0] d;
    ok = 0;
    z_req_a = 1; z_we_a = 1; z_addr_a = 5'd7; z_wdata_a = 16'h5A5A;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick;
      if (z_gnt_a) ok = 1;
    end
    z_req_a = 0; z_we_a = 0;
    tick;
    got = 0;
    l = -1;
    d = 0;
    z_req_a = 1;
    for (int i = 1; i <= 12 && !got; i++) begin
      tick;
      if (z_gnt_a) z_req_a = 0;
      if (z_rvalid_a) begin got = 1; l = i; d = z_rdata_a; end
    end
    z_req_a = 0;
    n_chk++;
    if (ok !== 1'b1) $display("FAIL t6_wr got=%b exp=1", ok);
    else n_pass++;
    n_chk++;
    if (l !== 5) $display("FAIL t6_lat got=%0d exp=5", l);
    else n_pass++;
    n_chk++;
    if (d !== 16'h5A5A) $display("FAIL t6_data got=%h exp=5a5a", d);
    else n_pass++;
  endtask

  task automatic test_exclusive;
    n_chk++;
    if (both_hi !== 0) $display("FAIL both_en got=%0d exp=0", both_hi);
    else n_pass++;
    n_chk++;
    if (en_bad !== 0) $display("FAIL en_outside_issue got=%0d exp=0", en_bad);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_tie;
    test_alternate;
    test_rw_hazard;
    test_reset_wait;
    test_lat3;
    tick;
    test_exclusive;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
